hls_loop_perf_monitor: RTL and testbench
========================================

// Module: hls_loop_perf_monitor
// PURPOSE
// Synthesizable multi-channel performance monitor for HLS-generated kernels. It watches the
//   ap_start/ap_done handshake and pipelined-loop iteration/stall strobes of NUM_CH kernels or
//   loops. Per channel it accumulates transaction count, last/min/max latency, iteration count
//   and stall cycles, and serves them over a register read port. It sits beside the DUT in the
//   top-level wrapper; it is the on-chip successor to the simulation-only dataflow monitors.
// PARAMETERS
// NUM_CH   4    number of monitored channels (1..16)
// CNT_W    32   width of every statistic counter (8..64)
// CH_W     $clog2(NUM_CH) (min 1)  channel-select width, derived, not overridable
// PORTS
// clock        in   1            sole clock, all logic on posedge
// reset        in   1            synchronous, active-high; restores all reset values
// ap_start     in   NUM_CH       per-channel kernel start
// ap_done      in   NUM_CH       per-channel kernel done (1-cycle pulse)
// iter_end     in   NUM_CH       per-channel loop iteration retired (enable & state & !block)
// iter_stall   in   NUM_CH       per-channel pipeline stalled (ap_block_*_subdone)
// clear        in   1            synchronous stats clear, same effect as reset
// finish       in   1            freeze: while high no counter or FSM changes
// rd_en        in   1            read request
// rd_ch        in   CH_W         channel select
// rd_sel       in   3            field select (see BEHAVIOUR)
// rd_valid     out  1            read data valid, 1 cycle after rd_en
// rd_data      out  CNT_W        read data
// rd_err       out  1            qualifies rd_valid: bad rd_ch/rd_sel
// busy         out  NUM_CH       per-channel BUSY state
// BEHAVIOUR
// Reset/clear: FSMs IDLE; all counters 0; min_lat all-ones (sentinel = no txn); ovf 0;
//   rd_valid 0, rd_data 0, rd_err 0, busy 0. reset wins over clear; clear wins over finish.
// Per-channel FSM, evaluated each cycle when finish=0:
//   IDLE: ap_start=1 -> lat_cnt<=1; if ap_done same cycle record lat=1, stay IDLE; else BUSY.
//   BUSY: lat_cnt++ (saturating). ap_done=1 -> record lat_cnt+1 (the done cycle counts);
//     then if ap_start also 1 -> lat_cnt<=1, stay BUSY (back-to-back); else -> IDLE.
//     ap_start while BUSY without ap_done is ignored.
//   record: txn_count++, last_lat<=L, min_lat<=min(min_lat,L), max_lat<=max(max_lat,L).
//   ap_done in IDLE with ap_start=0: ignored, no record.
// iter_count++ on every cycle with iter_end=1, in either state.
// stall_cycles++ on every cycle in BUSY with iter_stall=1 (IDLE stalls not counted).
// Saturation: every counter stops at 2^CNT_W-1, never wraps; any saturation event sets that
//   channel's sticky ovf bit (cleared only by reset/clear).
// finish=1: all counters, FSMs, ovf held; read port remains fully functional.
// Read port (registered, latency 1, one read per cycle, back-to-back allowed):
//   rd_sel 0 txn_count, 1 last_lat, 2 min_lat, 3 max_lat, 4 iter_count, 5 stall_cycles,
//   6 status = {zero-pad, ovf, busy}; 7 reserved.
//   rd_en=1 at cycle t -> rd_valid=1 at t+1 with value sampled at end of cycle t (pre-update).
//   rd_ch>=NUM_CH or rd_sel=7 -> rd_err=1, rd_data=0. rd_en=0 -> rd_valid=0, rd_data holds.
// Simultaneous record and read of same field returns the old value.
// Reset mid-transaction: channel returns to IDLE; a later ap_done is ignored.
// TESTING
// T1 ch0: start pulse at t0, done at t0+9 -> txn_count=1, last=min=max=10, busy[0] low at t0+10.
// T2 ch1: three txns of latency 5,12,7 back-to-back (done&start same cycle) -> txn=3, last=7,
//    min=5, max=12; busy[1] never drops between txns.
// T3 ch2: start; 20 BUSY cycles with iter_stall high 6 cycles, iter_end 14 pulses ->
//    stall_cycles=6, iter_count=14; 3 stall cycles in IDLE add 0.
// T4 CNT_W=8: hold ch3 BUSY 300 cycles then done -> last_lat=255, max_lat=255, status ovf=1.
// T5 raise finish mid-txn on ch0, toggle all inputs 50 cycles -> all fields unchanged, reads
//    still return data; then clear -> all 0, min_lat=all-ones, busy=0.
// T6 rd_ch=NUM_CH, rd_sel=7, and reset asserted mid-BUSY -> rd_err=1/rd_data=0; after reset a
//    stray ap_done leaves txn_count=0.

Source files
------------

// File: rtl/hls_loop_perf_monitor_if.sv
// Monitor-side bundle: kernel handshake/loop strobes in, register read port and busy flags out.
interface hls_loop_perf_monitor_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] iter_end;
  logic [NUM_CH-1:0] iter_stall;
  logic              clear;
  logic              finish;
  logic              rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [2:0]        rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_err;
  logic [NUM_CH-1:0] busy;

  // Wrapper / host side
  modport master (
    output ap_start, ap_done, iter_end, iter_stall, clear, finish, rd_en, rd_ch, rd_sel,
    input  rd_valid, rd_data, rd_err, busy
  );

  // Monitor side
  modport slave (
    input  ap_start, ap_done, iter_end, iter_stall, clear, finish, rd_en, rd_ch, rd_sel,
    output rd_valid, rd_data, rd_err, busy
  );
endinterface

// File: rtl/hls_loop_perf_monitor.sv
// Per-channel HLS kernel performance monitor: transaction latency stats, loop iteration and
// stall counts, all saturating with a sticky overflow flag, served over a 1-cycle read port.
module hls_loop_perf_monitor #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input logic                 clock,
  input logic                 reset,
  hls_loop_perf_monitor_if.slave bus
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]       state_q [NUM_CH];
  logic [0:0]       state_d [NUM_CH];
  logic [CNT_W-1:0] lat_q   [NUM_CH];
  logic [CNT_W-1:0] lat_d   [NUM_CH];
  logic [CNT_W-1:0] txn_q   [NUM_CH];
  logic [CNT_W-1:0] txn_d   [NUM_CH];
  logic [CNT_W-1:0] last_q  [NUM_CH];
  logic [CNT_W-1:0] last_d  [NUM_CH];
  logic [CNT_W-1:0] min_q   [NUM_CH];
  logic [CNT_W-1:0] min_d   [NUM_CH];
  logic [CNT_W-1:0] max_q   [NUM_CH];
  logic [CNT_W-1:0] max_d   [NUM_CH];
  logic [CNT_W-1:0] iter_q  [NUM_CH];
  logic [CNT_W-1:0] iter_d  [NUM_CH];
  logic [CNT_W-1:0] stall_q [NUM_CH];
  logic [CNT_W-1:0] stall_d [NUM_CH];
  logic             ovf_q   [NUM_CH];
  logic             ovf_d   [NUM_CH];

  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;
  logic             rd_err_q;
  logic [CNT_W-1:0] rd_data_d;
  logic             rd_bad;
  logic             ch_bad;
  logic [CH_W-1:0]  rd_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Next-state and next-statistics for every channel; finish freezes everything
  always_comb begin
    logic             rec;
    logic [CNT_W-1:0] rec_lat;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      lat_d[c]   = lat_q[c];
      txn_d[c]   = txn_q[c];
      last_d[c]  = last_q[c];
      min_d[c]   = min_q[c];
      max_d[c]   = max_q[c];
      iter_d[c]  = iter_q[c];
      stall_d[c] = stall_q[c];
      ovf_d[c]   = ovf_q[c];
      rec        = 1'b0;
      rec_lat    = '0;
      if (!bus.finish) begin
        case (state_q[c])
          IDLE: begin
            if (bus.ap_start[c]) begin
              lat_d[c] = CNT_ONE;
              if (bus.ap_done[c]) begin
                rec     = 1'b1;
                rec_lat = CNT_ONE;
              end else begin
                state_d[c] = BUSY;
              end
            end
          end
          BUSY: begin
            if (lat_q[c] == CNT_MAX) ovf_d[c] = 1'b1;
            lat_d[c] = sat_inc(lat_q[c]);
            if (bus.ap_done[c]) begin
              // The done cycle itself counts toward the latency
              rec     = 1'b1;
              rec_lat = sat_inc(lat_q[c]);
              if (bus.ap_start[c]) begin
                lat_d[c] = CNT_ONE;
              end else begin
                lat_d[c]   = '0;
                state_d[c] = IDLE;
              end
            end
          end
          default: state_d[c] = IDLE;
        endcase

        if (rec) begin
          if (txn_q[c] == CNT_MAX) ovf_d[c] = 1'b1;
          txn_d[c]  = sat_inc(txn_q[c]);
          last_d[c] = rec_lat;
          min_d[c]  = (rec_lat < min_q[c]) ? rec_lat : min_q[c];
          max_d[c]  = (rec_lat > max_q[c]) ? rec_lat : max_q[c];
        end

        if (bus.iter_end[c]) begin
          if (iter_q[c] == CNT_MAX) ovf_d[c] = 1'b1;
          iter_d[c] = sat_inc(iter_q[c]);
        end

        if (state_q[c] == BUSY && bus.iter_stall[c]) begin
          if (stall_q[c] == CNT_MAX) ovf_d[c] = 1'b1;
          stall_d[c] = sat_inc(stall_q[c]);
        end
      end
    end
  end

  // Read mux: out-of-range channel or reserved field reads as an error with zero data
  always_comb begin
    ch_bad    = (32'(bus.rd_ch) >= NUM_CH);
    rd_bad    = ch_bad || (bus.rd_sel == 3'd7);
    rd_idx    = ch_bad ? '0 : bus.rd_ch;
    rd_data_d = '0;
    if (!rd_bad) begin
      case (bus.rd_sel)
        3'd0:    rd_data_d = txn_q[rd_idx];
        3'd1:    rd_data_d = last_q[rd_idx];
        3'd2:    rd_data_d = min_q[rd_idx];
        3'd3:    rd_data_d = max_q[rd_idx];
        3'd4:    rd_data_d = iter_q[rd_idx];
        3'd5:    rd_data_d = stall_q[rd_idx];
        3'd6:    rd_data_d = CNT_W'({ovf_q[rd_idx], state_q[rd_idx]});
        default: rd_data_d = '0;
      endcase
    end
  end

  // Statistic and FSM registers; reset and clear both restore the idle/empty state
  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        lat_q[c]   <= '0;
        txn_q[c]   <= '0;
        last_q[c]  <= '0;
        min_q[c]   <= CNT_MAX;
        max_q[c]   <= '0;
        iter_q[c]  <= '0;
        stall_q[c] <= '0;
        ovf_q[c]   <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        lat_q[c]   <= lat_d[c];
        txn_q[c]   <= txn_d[c];
        last_q[c]  <= last_d[c];
        min_q[c]   <= min_d[c];
        max_q[c]   <= max_d[c];
        iter_q[c]  <= iter_d[c];
        stall_q[c] <= stall_d[c];
        ovf_q[c]   <= ovf_d[c];
      end
    end
  end

  // Read port registers: data and error hold when no read is issued
  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= rd_data_d;
        rd_err_q  <= rd_bad;
      end
    end
  end

  // Drive the interface outputs from registered state
  always_comb begin
    bus.rd_valid = rd_valid_q;
    bus.rd_data  = rd_data_q;
    bus.rd_err   = rd_err_q;
    bus.busy     = '0;
    for (int c = 0; c < NUM_CH; c++) bus.busy[c] = state_q[c][0];
  end
endmodule

// File: tb/tb_hls_loop_perf_monitor.sv
// Directed bench for hls_loop_perf_monitor (NUM_CH=5, CNT_W=8): stimulus phases, then a
// table of register reads with hand-computed expectations, then finish/clear/reset sequences.
module tb_hls_loop_perf_monitor;
  localparam int unsigned NCH = 5;
  localparam int unsigned CW  = 8;

  typedef struct {
    int         ch;
    int         sel;
    logic [7:0] data;
    logic       err;
  } rd_vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  rd_vec_t tbl [24];

  hls_loop_perf_monitor_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  hls_loop_perf_monitor #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic rd(input int ch, input int sel, input logic [7:0] exp, input string nm);
    bus.rd_en  = 1'b1;
    bus.rd_ch  = 3'(ch);
    bus.rd_sel = 3'(sel);
    step();
    bus.rd_en  = 1'b0;
    check({nm, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check({nm, "_err"}, 32'(bus.rd_err), 32'd0);
    check(nm, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic zero_strobes();
    bus.ap_start   = '0;
    bus.ap_done    = '0;
    bus.iter_end   = '0;
    bus.iter_stall = '0;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 8'd1,   1'b0};
    tbl[1]  = '{0, 1, 8'd10,  1'b0};
    tbl[2]  = '{0, 2, 8'd10,  1'b0};
    tbl[3]  = '{0, 3, 8'd10,  1'b0};
    tbl[4]  = '{0, 4, 8'd0,   1'b0};
    tbl[5]  = '{0, 6, 8'd0,   1'b0};
    tbl[6]  = '{1, 0, 8'd3,   1'b0};
    tbl[7]  = '{1, 1, 8'd7,   1'b0};
    tbl[8]  = '{1, 2, 8'd5,   1'b0};
    tbl[9]  = '{1, 3, 8'd12,  1'b0};
    tbl[10] = '{2, 0, 8'd1,   1'b0};
    tbl[11] = '{2, 1, 8'd22,  1'b0};
    tbl[12] = '{2, 4, 8'd14,  1'b0};
    tbl[13] = '{2, 5, 8'd6,   1'b0};
    tbl[14] = '{3, 1, 8'd255, 1'b0};
    tbl[15] = '{3, 3, 8'd255, 1'b0};
    tbl[16] = '{3, 6, 8'd2,   1'b0};
    tbl[17] = '{3, 0, 8'd1,   1'b0};
    tbl[18] = '{4, 0, 8'd0,   1'b0};
    tbl[19] = '{4, 2, 8'd255, 1'b0};
    tbl[20] = '{4, 6, 8'd0,   1'b0};
    tbl[21] = '{5, 0, 8'd0,   1'b1};
    tbl[22] = '{0, 7, 8'd0,   1'b1};
    tbl[23] = '{7, 3, 8'd0,   1'b1};

    zero_strobes();
    bus.clear  = 1'b0;
    bus.finish = 1'b0;
    bus.rd_en  = 1'b0;
    bus.rd_ch  = '0;
    bus.rd_sel = '0;
    steps(2);
    reset = 1'b0;

    // Reset state
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_rd_err", 32'(bus.rd_err), 32'd0);
    rd(0, 2, 8'd255, "rst_min");

    // ch0: start at t0, done at t0+9 -> latency 10
    bus.ap_start[0] = 1'b1; step(); bus.ap_start[0] = 1'b0;
    check("t1_busy_up", 32'(bus.busy[0]), 32'd1);
    steps(8);
    bus.ap_done[0] = 1'b1; step(); bus.ap_done[0] = 1'b0;
    check("t1_busy_down", 32'(bus.busy[0]), 32'd0);

    // ch1: back-to-back latencies 5, 12, 7
    bus.ap_start[1] = 1'b1; step(); bus.ap_start[1] = 1'b0;
    steps(3);
    bus.ap_start[1] = 1'b1; bus.ap_done[1] = 1'b1; step();
    bus.ap_start[1] = 1'b0; bus.ap_done[1] = 1'b0;
    check("t2_busy_b2b1", 32'(bus.busy[1]), 32'd1);
    steps(10);
    bus.ap_start[1] = 1'b1; bus.ap_done[1] = 1'b1; step();
    bus.ap_start[1] = 1'b0; bus.ap_done[1] = 1'b0;
    check("t2_busy_b2b2", 32'(bus.busy[1]), 32'd1);
    steps(5);
    bus.ap_done[1] = 1'b1; step(); bus.ap_done[1] = 1'b0;
    check("t2_busy_end", 32'(bus.busy[1]), 32'd0);

    // ch2: 20 BUSY cycles, 6 stalled and 14 iterations, then 3 stalls while IDLE
    bus.ap_start[2] = 1'b1; step(); bus.ap_start[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.iter_stall[2] = (i < 6);
      bus.iter_end[2]   = (i >= 6);
      step();
    end
    bus.iter_stall[2] = 1'b0; bus.iter_end[2] = 1'b0;
    bus.ap_done[2] = 1'b1; step(); bus.ap_done[2] = 1'b0;
    bus.iter_stall[2] = 1'b1; steps(3); bus.iter_stall[2] = 1'b0;

    // ch3: latency far beyond 8-bit range saturates
    bus.ap_start[3] = 1'b1; step(); bus.ap_start[3] = 1'b0;
    steps(298);
    bus.ap_done[3] = 1'b1; step(); bus.ap_done[3] = 1'b0;

    // Back-to-back table reads
    for (int i = 0; i < 24; i++) begin
      bus.rd_en  = 1'b1;
      bus.rd_ch  = 3'(tbl[i].ch);
      bus.rd_sel = 3'(tbl[i].sel);
      step();
      check($sformatf("tbl%0d_valid", i), 32'(bus.rd_valid), 32'd1);
      check($sformatf("tbl%0d_err", i), 32'(bus.rd_err), 32'(tbl[i].err));
      check($sformatf("tbl%0d_data", i), 32'(bus.rd_data), 32'(tbl[i].data));
    end
    bus.rd_en = 1'b0;
    bus.rd_ch = 3'd0; bus.rd_sel = 3'd0;
    step();
    check("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("idle_rd_hold", 32'(bus.rd_data), 32'd0);
    check("idle_rd_err_hold", 32'(bus.rd_err), 32'd1);

    // Read of txn_count in the same cycle as a 1-cycle record returns the old value
    bus.ap_start[0] = 1'b1; bus.ap_done[0] = 1'b1;
    rd(0, 0, 8'd1, "same_cyc_old");
    zero_strobes();
    rd(0, 0, 8'd2, "same_cyc_new");
    rd(0, 1, 8'd1, "lat1_last");
    rd(0, 2, 8'd1, "lat1_min");
    rd(0, 3, 8'd10, "lat1_max");

    // Freeze mid-transaction, hammer inputs, then clear
    bus.ap_start[0] = 1'b1; step(); bus.ap_start[0] = 1'b0;
    bus.finish = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.ap_start   = 5'($urandom);
      bus.ap_done    = 5'($urandom);
      bus.iter_end   = 5'($urandom);
      bus.iter_stall = 5'($urandom);
      step();
    end
    zero_strobes();
    rd(0, 0, 8'd2, "frz_txn0");
    rd(0, 1, 8'd1, "frz_last0");
    rd(0, 3, 8'd10, "frz_max0");
    rd(0, 6, 8'd1, "frz_status0");
    rd(1, 0, 8'd3, "frz_txn1");
    rd(2, 4, 8'd14, "frz_iter2");
    rd(2, 5, 8'd6, "frz_stall2");
    rd(3, 6, 8'd2, "frz_status3");
    rd(4, 4, 8'd0, "frz_iter4");
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
    bus.finish = 1'b0;
    check("clr_busy", 32'(bus.busy), 32'd0);
    check("clr_rd_valid", 32'(bus.rd_valid), 32'd0);
    rd(0, 0, 8'd0, "clr_txn0");
    rd(0, 2, 8'd255, "clr_min0");
    rd(0, 6, 8'd0, "clr_status0");
    rd(3, 6, 8'd0, "clr_status3");
    rd(2, 4, 8'd0, "clr_iter2");

    // Reset mid-BUSY, then a stray done must not record
    bus.ap_start[1] = 1'b1; step(); bus.ap_start[1] = 1'b0;
    steps(3);
    check("pre_rst_busy", 32'(bus.busy[1]), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    bus.ap_done[1] = 1'b1; step(); bus.ap_done[1] = 1'b0;
    rd(1, 0, 8'd0, "stray_done_txn");
    rd(1, 6, 8'd0, "stray_done_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
